axi_llc_ax_splitter: RTL and testbench
======================================

Name: axi_llc_ax_splitter

Overview:
Sequential front stage of the LLC descriptor path. It accepts one AXI4 AW or AR transaction over a valid/ready handshake and holds it in a register. It then emits one LLC descriptor per cache line touched, rewriting the held transaction to its remainder after each accepted descriptor. Per-line cutting and SPM/cached/error decode are computed combinationally from the held transaction.

Parameters:
Cfg, axi_llc_pkg::llc_cfg_t'{default:'0}, LLC static config (SetAssociativity, ByteOffsetLength, BlockOffsetLength, BlockSize, NumBlocks, NumLines)
AxiCfg, axi_llc_pkg::llc_axi_cfg_t'{default:'0}, AXI config; AddrWidthFull sets addr_t
chan_t, logic, AW or AR channel struct
Write, 1'b0, value driven on desc_o.rw (0 = AR, 1 = AW)
desc_t, logic, LLC descriptor struct
rule_t, axi_pkg::xbar_rule_64_t, address rule struct

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  reset, asynchronous, active-high
ax_chan_i  in  $bits(chan_t)  incoming Ax transaction
ax_chan_valid_i  in  1  Ax valid
ax_chan_ready_o  out  1  Ax ready
desc_o  out  $bits(desc_t)  current line descriptor
desc_valid_o  out  1  descriptor valid
desc_ready_i  in  1  descriptor ready
cached_rule_i  in  $bits(rule_t)  cached region; start_addr and end_addr used
spm_rule_i  in  $bits(rule_t)  SPM base; only start_addr used
busy_o  out  1  transaction held
desc_cnt_o  out  32  descriptors emitted (see Optional Feature)

Behaviour:
- Reset (async, rst_i=1): state IDLE, held register cleared, desc_valid_o=0, busy_o=0, desc_cnt_o=0. ax_chan_ready_o follows from IDLE and reads 1 once rst_i deasserts.
- FSM states: IDLE and BUSY.
- IDLE:
  - ax_chan_ready_o=1, desc_valid_o=0.
  - ax_chan_valid_i & ready: register ax_chan_i, go to BUSY.
- BUSY:
  - desc_valid_o=1, busy_o=1.
  - desc_o is a function of the held register only, so it is stable while stalled.
  - ax_chan_ready_o = desc_ready_i & desc_o.x_last. The ready is combinational; there is no path from valid to ready.
- Descriptor handshake in BUSY:
  - x_last=0: held.addr <= next line address; held.len <= held.len - beats_on_line. Stay in BUSY.
  - x_last=1 with a new Ax handshake in the same cycle: load the new transaction, stay in BUSY. No bubble between transactions.
  - x_last=1 with no new Ax: go to IDLE.
- Latency: first descriptor valid 1 cycle after the Ax handshake. With desc_ready_i=1, sustained rate is 1 descriptor/cycle.
- Cut arithmetic (all in addr_t width, LineOffset = ByteOffsetLength + BlockOffsetLength):
  - line_addr = addr with low LineOffset bits cleared; next_line = line_addr + 2^LineOffset.
  - bytes_on_line = next_line - addr; beats_on_line = len_t'((bytes_on_line-1) >> size) + 1.
  - Cut when (beats_on_line-1) < len and burst != FIXED: a_x_len = beats_on_line-1, x_last=0.
  - Otherwise a_x_len = len, x_last=1. FIXED bursts always produce exactly one descriptor.
  - WRAP is treated as INCR.
- Descriptor fields:
  - a_x_id, addr, size, burst, lock, prot and cache are copied from the held transaction.
  - rw = Write; x_resp = OKAY; all other fields are 0 unless set by the decode below.
- Address decode (rule 0 = cached, rules 1..SetAssociativity = per-way SPM regions):
  - Each SPM way spans (BlockSize/8)*NumBlocks*NumLines bytes, contiguous upward from spm_rule_i.start_addr.
  - Hit rule 0: spm=0.
  - Hit rule i (i>=1): spm=1, way_ind = one-hot(i-1).
  - No hit: spm=1, way_ind = 1 (way 0), x_resp = SLVERR.
  - Decode is redone per descriptor on the current held address.
- Rule inputs must be stable while busy_o=1; a change mid-burst affects later descriptors only.
- Reset mid-operation: the held transaction is discarded. desc_valid_o drops asynchronously with rst_i and no further descriptor is emitted.

Optional Feature:
AXI_LLC_SPLITTER_CNT_EN
- Defined: desc_cnt_o increments by 1 on every descriptor handshake and saturates at 32'hFFFF_FFFF. It is cleared only by reset.
- Undefined: desc_cnt_o is tied to 0 and the counter logic is absent.
- Functional outputs are identical in both cases.

Test Plan:
(Cfg: 8-byte beats, 8 beats/line, 64-byte lines; cached region 0x1000_0000..0x2000_0000.)
1. INCR addr 0x1000_0038, size 3, len 3 -> desc A: addr ..38, a_x_len 0, x_last 0; desc B: addr ..40, a_x_len 2, x_last 1; spm 0 for both.
2. FIXED addr 0x1000_0038, size 3, len 7 -> single desc: a_x_len 7, x_last 1.
3. Test 1 with desc_ready_i=0 for 5 cycles -> desc_o stable throughout, ax_chan_ready_o=0, no advance; resumes correctly after release.
4. Two back-to-back Ax, valid held high, desc_ready_i=1 -> second Ax accepted in the x_last handshake cycle; its first desc valid the next cycle; desc_valid_o never drops.
5. addr 0x3000_0000 (no rule hit) -> spm 1, way_ind 1, x_resp SLVERR; addr spm_rule_i.start_addr + one way size -> spm 1, way_ind 2'b10.
6. rst_i pulse while desc B of test 1 is pending -> desc_valid_o=0 and busy_o=0 immediately; no stale desc after release. With AXI_LLC_SPLITTER_CNT_EN defined, desc_cnt_o=0 after reset and reads 2 after test 1 completes.

Source files
------------

// File: rtl/axi_llc_ax_splitter.sv
// Splits one held AXI AW/AR transaction into per-cache-line LLC descriptors.
// Optional descriptor counter on desc_cnt_o: define AXI_LLC_SPLITTER_CNT_EN.

package axi_llc_ax_splitter_pkg;

  localparam int unsigned NumWays = 4;

  typedef logic [3:0]  llc_id_t;
  typedef logic [31:0] llc_addr_t;
  typedef logic [7:0]  llc_len_t;

  localparam logic [1:0] BurstFixed = 2'b00;
  localparam logic [1:0] BurstIncr  = 2'b01;
  localparam logic [1:0] BurstWrap  = 2'b10;
  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlvErr = 2'b10;

  typedef struct packed {
    int unsigned SetAssociativity;
    int unsigned NumLines;
    int unsigned NumBlocks;
    int unsigned BlockSize;
    int unsigned BlockOffsetLength;
    int unsigned ByteOffsetLength;
  } llc_cfg_t;

  typedef struct packed {
    int unsigned IdWidth;
    int unsigned AddrWidthFull;
  } llc_axi_cfg_t;

  typedef struct packed {
    llc_id_t    id;
    llc_addr_t  addr;
    llc_len_t   len;
    logic [2:0] size;
    logic [1:0] burst;
    logic       lock;
    logic [3:0] cache;
    logic [2:0] prot;
    logic [3:0] qos;
    logic [3:0] region;
  } ax_chan_t;

  typedef struct packed {
    llc_id_t              a_x_id;
    llc_addr_t            a_x_addr;
    llc_len_t             a_x_len;
    logic [2:0]           a_x_size;
    logic [1:0]           a_x_burst;
    logic                 a_x_lock;
    logic [3:0]           a_x_cache;
    logic [2:0]           a_x_prot;
    logic [1:0]           x_resp;
    logic                 x_last;
    logic                 spm;
    logic                 rw;
    logic [NumWays-1:0]   way_ind;
    logic                 evict;
    logic                 refill;
    logic                 flush;
  } llc_desc_t;

  typedef struct packed {
    logic [31:0] idx;
    logic [63:0] start_addr;
    logic [63:0] end_addr;
  } xbar_rule_64_t;

endpackage

module axi_llc_ax_splitter
  import axi_llc_ax_splitter_pkg::*;
#(
  parameter llc_cfg_t Cfg = '{
    SetAssociativity:  NumWays,
    NumLines:          32'd256,
    NumBlocks:         32'd8,
    BlockSize:         32'd64,
    BlockOffsetLength: 32'd3,
    ByteOffsetLength:  32'd3
  },
  parameter llc_axi_cfg_t AxiCfg = '{
    IdWidth:       32'd4,
    AddrWidthFull: 32'd32
  },
  parameter type  chan_t = ax_chan_t,
  parameter logic Write  = 1'b0,
  parameter type  desc_t = llc_desc_t,
  parameter type  rule_t = xbar_rule_64_t
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  chan_t       ax_chan_i,
  input  logic        ax_chan_valid_i,
  output logic        ax_chan_ready_o,
  output desc_t       desc_o,
  output logic        desc_valid_o,
  input  logic        desc_ready_i,
  input  rule_t       cached_rule_i,
  input  rule_t       spm_rule_i,
  output logic        busy_o,
  output logic [31:0] desc_cnt_o
);

  localparam int unsigned AW = AxiCfg.AddrWidthFull;
  localparam int unsigned LineOffset =
    Cfg.ByteOffsetLength + Cfg.BlockOffsetLength;
  localparam int unsigned NW = Cfg.SetAssociativity;

  typedef logic [AW-1:0] addr_t;
  typedef logic [7:0]    len_t;
  typedef logic [NW-1:0] way_t;

  localparam addr_t LineBytes = addr_t'(1) << LineOffset;
  localparam addr_t LineMask  = ~(LineBytes - addr_t'(1));
  localparam addr_t WaySize   =
    addr_t'(Cfg.BlockSize / 32'd8 * Cfg.NumBlocks * Cfg.NumLines);

  typedef enum logic {
    Idle = 1'b0,
    Busy = 1'b1
  } state_e;

  state_e state_q;
  state_e state_d;
  chan_t  held_q;

  addr_t cur_addr;
  len_t  cur_len;
  addr_t line_addr;
  addr_t next_line;
  addr_t bytes_on_line;
  addr_t beats_m1_wide;
  len_t  beats_on_line;
  logic  x_last;

  logic  cached_hit;
  logic  spm_hit;
  way_t  spm_way;
  addr_t cached_lo;
  addr_t cached_hi;
  addr_t spm_base;

  logic  ax_hs;
  logic  desc_hs;
  desc_t desc;

  assign ax_hs   = ax_chan_valid_i & ax_chan_ready_o;
  assign desc_hs = desc_valid_o & desc_ready_i;

  // Line cut, derived only from the held transaction
  assign cur_addr      = addr_t'(held_q.addr);
  assign cur_len       = len_t'(held_q.len);
  assign line_addr     = cur_addr & LineMask;
  assign next_line     = line_addr + LineBytes;
  assign bytes_on_line = next_line - cur_addr;
  assign beats_m1_wide = (bytes_on_line - addr_t'(1)) >> held_q.size;
  assign beats_on_line = len_t'(beats_m1_wide) + len_t'(1);

  assign x_last = (held_q.burst == BurstFixed) ||
                  !((beats_on_line - len_t'(1)) < cur_len);

  // Address decode
  assign cached_lo  = addr_t'(cached_rule_i.start_addr);
  assign cached_hi  = addr_t'(cached_rule_i.end_addr);
  assign spm_base   = addr_t'(spm_rule_i.start_addr);
  assign cached_hit = (cur_addr >= cached_lo) && (cur_addr < cached_hi);

  always_comb begin
    addr_t lo;
    spm_hit = 1'b0;
    spm_way = '0;
    lo      = spm_base;
    for (int unsigned i = 0; i < NW; i++) begin
      lo = spm_base + addr_t'(i) * WaySize;
      if (!spm_hit && (cur_addr >= lo) &&
          (cur_addr < lo + WaySize)) begin
        spm_hit    = 1'b1;
        spm_way[i] = 1'b1;
      end
    end
  end

  always_comb begin
    desc           = '0;
    desc.a_x_id    = held_q.id;
    desc.a_x_addr  = held_q.addr;
    desc.a_x_size  = held_q.size;
    desc.a_x_burst = held_q.burst;
    desc.a_x_lock  = held_q.lock;
    desc.a_x_cache = held_q.cache;
    desc.a_x_prot  = held_q.prot;
    desc.rw        = Write;
    desc.x_resp    = RespOkay;
    desc.x_last    = x_last;
    desc.a_x_len   = x_last ? cur_len
                            : beats_on_line - len_t'(1);
    unique case (1'b1)
      cached_hit: desc.spm = 1'b0;
      spm_hit: begin
        desc.spm     = 1'b1;
        desc.way_ind = spm_way;
      end
      default: begin
        desc.spm     = 1'b1;
        desc.way_ind = way_t'(1);
        desc.x_resp  = RespSlvErr;
      end
    endcase
  end

  assign desc_o = desc;

  // FSM: state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= Idle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      Idle: if (ax_hs) state_d = Busy;
      Busy: if (desc_hs && x_last && !ax_hs) state_d = Idle;
      default: state_d = Idle;
    endcase
  end

  // FSM: outputs
  always_comb begin
    desc_valid_o    = 1'b0;
    busy_o          = 1'b0;
    ax_chan_ready_o = 1'b0;
    unique case (state_q)
      Idle: ax_chan_ready_o = 1'b1;
      Busy: begin
        desc_valid_o    = 1'b1;
        busy_o          = 1'b1;
        ax_chan_ready_o = desc_ready_i & x_last;
      end
      default: ;
    endcase
  end

  // Held transaction; rewritten to its remainder after each cut
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      held_q <= '0;
    end else if (ax_hs) begin
      held_q <= ax_chan_i;
    end else if (desc_hs && !x_last) begin
      held_q.addr <= next_line;
      held_q.len  <= cur_len - beats_on_line;
    end
  end

`ifdef AXI_LLC_SPLITTER_CNT_EN
  logic [31:0] cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (desc_hs && (cnt_q != 32'hFFFF_FFFF)) begin
      cnt_q <= cnt_q + 32'd1;
    end
  end

  assign desc_cnt_o = cnt_q;
`else
  assign desc_cnt_o = '0;
`endif

  logic unused_bits;
  assign unused_bits = ^{held_q, cached_rule_i, spm_rule_i};

endmodule

// File: tb/tb_axi_llc_ax_splitter.sv
// Directed bench for axi_llc_ax_splitter: line cuts, stalls,
// back-to-back transactions, SPM/error decode and async reset.

module tb_axi_llc_ax_splitter;
  import axi_llc_ax_splitter_pkg::*;

`ifdef AXI_LLC_SPLITTER_CNT_EN
  localparam logic [31:0] CntT1 = 32'd2;
`else
  localparam logic [31:0] CntT1 = 32'd0;
`endif

  localparam logic [31:0] SpmBase = 32'h0400_0000;
  localparam logic [31:0] WayBytes = 32'h0000_4000;

  logic          clk = 1'b0;
  logic          rst;
  ax_chan_t      ax_chan;
  logic          ax_valid;
  logic          ax_ready;
  llc_desc_t     desc;
  logic          desc_valid;
  logic          desc_ready;
  xbar_rule_64_t cached_rule;
  xbar_rule_64_t spm_rule;
  logic          busy;
  logic [31:0]   desc_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  axi_llc_ax_splitter dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .ax_chan_i       (ax_chan),
    .ax_chan_valid_i (ax_valid),
    .ax_chan_ready_o (ax_ready),
    .desc_o          (desc),
    .desc_valid_o    (desc_valid),
    .desc_ready_i    (desc_ready),
    .cached_rule_i   (cached_rule),
    .spm_rule_i      (spm_rule),
    .busy_o          (busy),
    .desc_cnt_o      (desc_cnt)
  );

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_desc(input string tag,
                            input logic [31:0] addr,
                            input logic [7:0] len,
                            input logic last,
                            input logic spm,
                            input logic [3:0] way,
                            input logic [1:0] resp);
    check({tag, " valid"}, desc_valid, 1'b1);
    check({tag, " addr"}, desc.a_x_addr, addr);
    check({tag, " len"}, desc.a_x_len, len);
    check({tag, " last"}, desc.x_last, last);
    check({tag, " spm"}, desc.spm, spm);
    check({tag, " way"}, desc.way_ind, way);
    check({tag, " resp"}, desc.x_resp, resp);
  endtask

  function automatic ax_chan_t mk(input logic [31:0] addr,
                                  input logic [7:0] len,
                                  input logic [2:0] size,
                                  input logic [1:0] burst,
                                  input logic [3:0] id);
    ax_chan_t c;
    c       = '0;
    c.addr  = addr;
    c.len   = len;
    c.size  = size;
    c.burst = burst;
    c.id    = id;
    c.cache = 4'h3;
    c.prot  = 3'h2;
    return c;
  endfunction

  // Test-1 transaction from idle with desc_ready high
  task automatic run_t1(input string tag);
    @(negedge clk);
    ax_chan    = mk(32'h1000_0038, 8'd3, 3'd3, BurstIncr, 4'd5);
    ax_valid   = 1'b1;
    desc_ready = 1'b1;
    #1 check({tag, " idle ready"}, ax_ready, 1'b1);
    @(negedge clk);
    ax_valid = 1'b0;
    #1;
    check_desc({tag, " A"}, 32'h1000_0038, 8'd0, 1'b0, 1'b0, 4'h0,
               RespOkay);
    check({tag, " A id"}, desc.a_x_id, 4'd5);
    check({tag, " A cache"}, desc.a_x_cache, 4'h3);
    check({tag, " A rw"}, desc.rw, 1'b0);
    check({tag, " A ax_ready"}, ax_ready, 1'b0);
    check({tag, " A busy"}, busy, 1'b1);
    @(negedge clk);
    #1;
    check_desc({tag, " B"}, 32'h1000_0040, 8'd2, 1'b1, 1'b0, 4'h0,
               RespOkay);
    check({tag, " B ax_ready"}, ax_ready, 1'b1);
    @(negedge clk);
    #1;
    check({tag, " done valid"}, desc_valid, 1'b0);
    check({tag, " done busy"}, busy, 1'b0);
    check({tag, " cnt"}, desc_cnt, CntT1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst         = 1'b1;
    ax_chan     = '0;
    ax_valid    = 1'b0;
    desc_ready  = 1'b0;
    cached_rule = '{idx: 32'd0,
                    start_addr: 64'h1000_0000,
                    end_addr: 64'h2000_0000};
    spm_rule    = '{idx: 32'd1,
                    start_addr: {32'h0, SpmBase},
                    end_addr: 64'h0};

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst valid", desc_valid, 1'b0);
    check("rst busy", busy, 1'b0);
    check("rst cnt", desc_cnt, 32'd0);
    rst = 1'b0;
    #1 check("post-rst ready", ax_ready, 1'b1);

    // 1: INCR crossing a line boundary
    run_t1("t1");

    // 2: FIXED never cut
    @(negedge clk);
    ax_chan  = mk(32'h1000_0038, 8'd7, 3'd3, BurstFixed, 4'd1);
    ax_valid = 1'b1;
    @(negedge clk);
    ax_valid = 1'b0;
    #1;
    check_desc("t2", 32'h1000_0038, 8'd7, 1'b1, 1'b0, 4'h0, RespOkay);
    check("t2 burst", desc.a_x_burst, BurstFixed);
    @(negedge clk);
    #1 check("t2 done", desc_valid, 1'b0);

    // 3: stall for 5 cycles
    @(negedge clk);
    ax_chan    = mk(32'h1000_0038, 8'd3, 3'd3, BurstIncr, 4'd2);
    ax_valid   = 1'b1;
    desc_ready = 1'b0;
    @(negedge clk);
    ax_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("t3 stall addr", desc.a_x_addr, 32'h1000_0038);
      check("t3 stall len", desc.a_x_len, 8'd0);
      check("t3 stall ready", ax_ready, 1'b0);
      check("t3 stall valid", desc_valid, 1'b1);
      @(negedge clk);
    end
    desc_ready = 1'b1;
    #1;
    check_desc("t3 A", 32'h1000_0038, 8'd0, 1'b0, 1'b0, 4'h0, RespOkay);
    @(negedge clk);
    #1;
    check_desc("t3 B", 32'h1000_0040, 8'd2, 1'b1, 1'b0, 4'h0, RespOkay);
    @(negedge clk);
    #1 check("t3 done", desc_valid, 1'b0);

    // 4: back-to-back, valid held high
    @(negedge clk);
    ax_chan  = mk(32'h1000_0038, 8'd3, 3'd3, BurstIncr, 4'd3);
    ax_valid = 1'b1;
    @(negedge clk);
    ax_chan = mk(32'h1000_0100, 8'd1, 3'd3, BurstIncr, 4'd4);
    #1;
    check_desc("t4 A", 32'h1000_0038, 8'd0, 1'b0, 1'b0, 4'h0, RespOkay);
    check("t4 A ready", ax_ready, 1'b0);
    @(negedge clk);
    #1;
    check_desc("t4 B", 32'h1000_0040, 8'd2, 1'b1, 1'b0, 4'h0, RespOkay);
    check("t4 B ready", ax_ready, 1'b1);
    @(negedge clk);
    ax_valid = 1'b0;
    #1;
    check_desc("t4 C", 32'h1000_0100, 8'd1, 1'b1, 1'b0, 4'h0, RespOkay);
    check("t4 C id", desc.a_x_id, 4'd4);
    @(negedge clk);
    #1 check("t4 done", desc_valid, 1'b0);

    // 5: decode miss, then SPM way 1
    @(negedge clk);
    ax_chan  = mk(32'h3000_0000, 8'd0, 3'd3, BurstIncr, 4'd6);
    ax_valid = 1'b1;
    @(negedge clk);
    ax_chan = mk(SpmBase + WayBytes, 8'd0, 3'd3, BurstIncr, 4'd7);
    #1;
    check_desc("t5 miss", 32'h3000_0000, 8'd0, 1'b1, 1'b1, 4'b0001,
               RespSlvErr);
    @(negedge clk);
    ax_valid = 1'b0;
    #1;
    check_desc("t5 way1", SpmBase + WayBytes, 8'd0, 1'b1, 1'b1,
               4'b0010, RespOkay);
    @(negedge clk);
    #1 check("t5 done", desc_valid, 1'b0);

    // 6: reset while desc B pending
    @(negedge clk);
    ax_chan    = mk(32'h1000_0038, 8'd3, 3'd3, BurstIncr, 4'd8);
    ax_valid   = 1'b1;
    desc_ready = 1'b1;
    @(negedge clk);
    ax_valid = 1'b0;
    #1 check("t6 A addr", desc.a_x_addr, 32'h1000_0038);
    @(negedge clk);
    desc_ready = 1'b0;
    #1 check("t6 B addr", desc.a_x_addr, 32'h1000_0040);
    #2 rst = 1'b1;
    #1;
    check("t6 rst valid", desc_valid, 1'b0);
    check("t6 rst busy", busy, 1'b0);
    check("t6 rst cnt", desc_cnt, 32'd0);
    @(negedge clk);
    rst        = 1'b0;
    desc_ready = 1'b1;
    #1 check("t6 rel ready", ax_ready, 1'b1);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      #1 check("t6 no stale", desc_valid, 1'b0);
    end
    run_t1("t6 rerun");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
